// File: rtl/sram_access_ctrl.sv
// SRAM array access sequencer: precharge, wordline/column access, sense, done.
// All array-side controls are registered from the next state so they switch glitch-free.
module sram_access_ctrl #(
    parameter int ADDR_W   = 6,
    parameter int COL_BITS = 2,
    parameter int DATA_W   = 8,
    parameter int ACC_CYC  = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic                                req_we,
    input  logic [ADDR_W-1:0]                   req_addr,
    input  logic [DATA_W-1:0]                   req_wdata,
    output logic                                rsp_valid,
    output logic [DATA_W-1:0]                   rsp_rdata,
    output logic                                precharge,
    output logic [(1<<(ADDR_W-COL_BITS))-1:0]   wl_sel,
    output logic [(1<<COL_BITS)-1:0]            col_sel,
    output logic                                write_en,
    output logic [DATA_W-1:0]                   wdata_drv,
    output logic                                sense_en,
    input  logic [DATA_W-1:0]                   sa_data
);

    localparam int ROW_W = ADDR_W - COL_BITS;
    localparam int NROW  = 1 << ROW_W;
    localparam int NCOL  = 1 << COL_BITS;
    localparam logic [3:0] ACC_LOAD = 4'(ACC_CYC - 1);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // PRE   | bitline precharge, one cycle
    // ACC   | wordline + column mux on for ACC_CYC cycles, write drivers on for writes
    // SENSE | sense amp enabled, read data captured at the end of the cycle
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACC,
        S_SENSE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_next;
    logic                w_accept;

    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                r_precharge;
    logic [NROW-1:0]     r_wl_sel;
    logic [NCOL-1:0]     r_col_sel;
    logic                r_write_en;
    logic [DATA_W-1:0]   r_wdata_drv;
    logic                r_sense_en;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rdata;

    logic [NROW-1:0]     w_row_oh;
    logic [NCOL-1:0]     w_col_oh;
    logic                w_in_array;
    logic                w_drive_wr;

    assign req_ready = (r_state == S_IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_PRE;
            end
            S_PRE: begin
                w_next     = S_ACC;
                w_cnt_next = ACC_LOAD;
            end
            S_ACC: begin
                if (r_cnt == 4'd0) w_next = r_we ? S_DONE : S_SENSE;
                else               w_cnt_next = r_cnt - 4'd1;
            end
            S_SENSE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_row_oh = '0;
        w_col_oh = '0;
        w_row_oh[r_addr[ADDR_W-1:COL_BITS]] = 1'b1;
        w_col_oh[r_addr[COL_BITS-1:0]]      = 1'b1;
    end

    // Wordline and column mux stay on through SENSE so the sense amp sees the selected cell.
    assign w_in_array = (w_next == S_ACC) || (w_next == S_SENSE);
    assign w_drive_wr = (w_next == S_ACC) && r_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_precharge <= 1'b0;
            r_wl_sel    <= '0;
            r_col_sel   <= '0;
            r_write_en  <= 1'b0;
            r_wdata_drv <= '0;
            r_sense_en  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            r_precharge <= (w_next == S_PRE);
            r_wl_sel    <= w_in_array ? w_row_oh : '0;
            r_col_sel   <= w_in_array ? w_col_oh : '0;
            r_write_en  <= w_drive_wr;
            r_wdata_drv <= w_drive_wr ? r_wdata : '0;
            r_sense_en  <= (w_next == S_SENSE);
            r_rsp_valid <= (w_next == S_DONE);
            if (r_state == S_SENSE) r_rdata <= sa_data;
        end
    end

    assign precharge = r_precharge;
    assign wl_sel    = r_wl_sel;
    assign col_sel   = r_col_sel;
    assign write_en  = r_write_en;
    assign wdata_drv = r_wdata_drv;
    assign sense_en  = r_sense_en;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with a response scoreboard; expected read data
// is queued at issue time and popped by an independent monitor on rsp_valid.
module tb_sram_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [5:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        precharge;
    logic [15:0] wl_sel;
    logic [3:0]  col_sel;
    logic        write_en;
    logic [7:0]  wdata_drv;
    logic        sense_en;
    logic [7:0]  sa_data;

    int errors = 0;
    int checks = 0;
    int rsp_seen = 0;
    int pushed = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_rdata;

    sram_access_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .precharge(precharge), .wl_sel(wl_sel), .col_sel(col_sel),
        .write_en(write_en), .wdata_drv(wdata_drv), .sense_en(sense_en),
        .sa_data(sa_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Issues one request; leaves the bench at the accept edge + 1ns (cycle 0).
    task automatic send(input logic we, input logic [5:0] a, input logic [7:0] d, input logic scored);
        @(negedge clk);
        chk("ready_before_accept", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        if (scored) begin
            if (!we) model_rdata = sa_data;
            exp_q.push_back(model_rdata);
            pushed++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    // Scoreboard monitor plus array-safety invariants, sampled on the falling edge.
    always @(negedge clk) begin
        logic [7:0] e;
        chk("inv_precharge_col", 32'(precharge && (|col_sel)), 32'd0);
        chk("inv_we_onehot", 32'(write_en && !$onehot(col_sel)), 32'd0);
        if (rsp_valid) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid=1 rdata=0x%0h with no request outstanding at %0t",
                         rsp_rdata, $time);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; sa_data = '0;
        model_rdata = 8'h00;

        // Reset held two cycles
        cyc(); cyc();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_outputs", {precharge, write_en, sense_en, rsp_valid, 4'b0, col_sel, wl_sel}, 32'd0);
        chk("rst_data", {16'd0, wdata_drv, rsp_rdata}, 32'd0);
        reset = 1'b0;
        cyc();
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Write 0x2D <- 0xA5: row 11, column 1
        send(1'b1, 6'h2D, 8'hA5, 1'b1);
        cyc();
        chk("wr_c1_precharge", 32'(precharge), 32'd1);
        chk("wr_c1_sel", {12'd0, col_sel, wl_sel}, 32'd0);
        chk("wr_c1_en", {write_en, sense_en}, 32'd0);
        chk("wr_c1_ready", 32'(req_ready), 32'd0);
        for (int c = 2; c <= 3; c++) begin
            cyc();
            chk("wr_acc_wl", 32'(wl_sel), 32'h0800);
            chk("wr_acc_col", 32'(col_sel), 32'b0010);
            chk("wr_acc_we", 32'(write_en), 32'd1);
            chk("wr_acc_wdata", 32'(wdata_drv), 32'hA5);
            chk("wr_acc_pre", 32'(precharge), 32'd0);
            chk("wr_acc_rsp", 32'(rsp_valid), 32'd0);
        end
        cyc();
        chk("wr_c4_rsp", 32'(rsp_valid), 32'd1);
        chk("wr_c4_quiet", {precharge, write_en, sense_en, 9'd0, col_sel, wl_sel}, 32'd0);
        chk("wr_c4_ready", 32'(req_ready), 32'd0);

        // Read 0x2D with sense amp returning 0xA5
        sa_data = 8'hA5;
        send(1'b0, 6'h2D, 8'h00, 1'b1);
        cyc();
        chk("rd_c1_precharge", 32'(precharge), 32'd1);
        for (int c = 2; c <= 3; c++) begin
            cyc();
            chk("rd_acc_col", 32'(col_sel), 32'b0010);
            chk("rd_acc_wl", 32'(wl_sel), 32'h0800);
            chk("rd_acc_we", 32'(write_en), 32'd0);
            chk("rd_acc_wdata", 32'(wdata_drv), 32'd0);
            chk("rd_acc_sense", 32'(sense_en), 32'd0);
        end
        cyc();
        chk("rd_c4_sense", 32'(sense_en), 32'd1);
        chk("rd_c4_held", {12'd0, col_sel, wl_sel}, {12'd0, 4'b0010, 16'h0800});
        chk("rd_c4_rsp", 32'(rsp_valid), 32'd0);
        cyc();
        chk("rd_c5_rsp", 32'(rsp_valid), 32'd1);
        chk("rd_c5_rdata", 32'(rsp_rdata), 32'hA5);
        chk("rd_c5_sense", 32'(sense_en), 32'd0);
        sa_data = 8'h00;

        // Busy: a second request held during ACC must be ignored
        send(1'b1, 6'h10, 8'h3C, 1'b1);
        cyc();
        cyc();
        chk("busy_c2_wl", 32'(wl_sel), 32'h0010);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h00;
        cyc();
        chk("busy_c3_ready", 32'(req_ready), 32'd0);
        chk("busy_c3_wl", 32'(wl_sel), 32'h0010);
        chk("busy_c3_col", 32'(col_sel), 32'b0001);
        chk("busy_c3_wdata", 32'(wdata_drv), 32'h3C);
        cyc();
        chk("busy_c4_rsp", 32'(rsp_valid), 32'd1);
        chk("busy_c4_rdata_held", 32'(rsp_rdata), 32'hA5);
        req_valid = 1'b0;
        cyc();
        chk("busy_c5_ready", 32'(req_ready), 32'd1);
        cyc();
        chk("busy_c6_no_accept", 32'(precharge), 32'd0);

        // Reset during the first ACC cycle of a write
        send(1'b1, 6'h2D, 8'h77, 1'b0);
        cyc();
        cyc();
        chk("abort_c2_we", 32'(write_en), 32'd1);
        reset = 1'b1;
        cyc();
        chk("abort_we", 32'(write_en), 32'd0);
        chk("abort_wl", 32'(wl_sel), 32'd0);
        chk("abort_misc", {precharge, sense_en, rsp_valid, 5'd0, wdata_drv, rsp_rdata, 4'd0, col_sel}, 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        model_rdata = 8'h00;
        cyc();
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        repeat (6) cyc();

        // Column sweep: reads at 0..3
        for (int i = 0; i < 4; i++) begin
            sa_data = 8'h10 + 8'(i);
            send(1'b0, 6'(i), 8'h00, 1'b1);
            cyc();
            chk("sweep_pre_col", 32'(col_sel), 32'd0);
            cyc();
            chk("sweep_col", 32'(col_sel), 32'(4'b0001 << i));
            chk("sweep_wl", 32'(wl_sel), 32'h0001);
            cyc(); cyc(); cyc();
            chk("sweep_rdata", 32'(rsp_rdata), 32'h10 + 32'(i));
        end
        sa_data = 8'h00;

        repeat (5) cyc();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("one_rsp_per_accept", 32'(rsp_seen), 32'(pushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning total word-address width.
REQ-002 SHALL have parameter COL_BITS, default 2, meaning column-mux select bits; mux ratio NCOL = 2^COL_BITS.
REQ-003 SHALL have parameter DATA_W, default 8, meaning data word width.
REQ-004 SHALL have parameter ACC_CYC, default 2 (legal range 1..15), meaning wordline/column-access cycles.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates occur on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning reset; it is synchronous and active-high.
REQ-007 SHALL have port req_valid, input, 1, meaning an access request is present.
REQ-008 SHALL have port req_ready, output, 1, meaning the controller accepts a request this cycle.
REQ-009 SHALL have port req_we, input, 1, meaning 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, ADDR_W, meaning the word address; upper bits give the row, low COL_BITS give the column.
REQ-011 SHALL have port req_wdata, input, DATA_W, meaning the write data.
REQ-012 SHALL have port rsp_valid, output, 1, meaning a one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata, output, DATA_W, meaning read data, valid while rsp_valid=1.
REQ-014 SHALL have port precharge, output, 1, meaning the bitline precharge enable.
REQ-015 SHALL have port wl_sel, output, 2^(ADDR_W-COL_BITS), meaning the one-hot wordline enable.
REQ-016 SHALL have port col_sel, output, NCOL, meaning the one-hot column-mux transmission-gate select (drives each mux S input).
REQ-017 SHALL have port write_en, output, 1, meaning the array write direction / write-driver enable.
REQ-018 SHALL have port wdata_drv, output, DATA_W, meaning the data driven onto the selected bitlines.
REQ-019 SHALL have port sense_en, output, 1, meaning the sense-amp enable.
REQ-020 SHALL have port sa_data, input, DATA_W, meaning the sense-amp output.

Function
REQ-021 SHALL implement FSM states IDLE, PRE, ACC, SENSE and DONE, with all array-side outputs registered (glitch-free).
REQ-022 SHALL assert req_ready=1 only in IDLE; a request is accepted on an edge where req_valid && req_ready, latching req_we, req_addr and req_wdata.
REQ-023 SHALL transition IDLE->PRE on accept; otherwise IDLE holds.
REQ-024 SHALL, in PRE, last exactly 1 cycle with precharge=1 and wl_sel, col_sel, write_en and sense_en all 0; PRE->ACC.
REQ-025 SHALL, in ACC, last exactly ACC_CYC cycles (internal down-counter): wl_sel one-hot at the latched row, col_sel one-hot at the latched column, precharge=0; for a write, write_en=1 and wdata_drv=latched data; for a read, write_en=0 and wdata_drv=0.
REQ-026 SHALL go ACC->DONE for a write and ACC->SENSE for a read.
REQ-027 SHALL, in SENSE, last 1 cycle with sense_en=1 and wl_sel/col_sel held; sa_data is captured into rsp_rdata at the end of SENSE; SENSE->DONE.
REQ-028 SHALL, in DONE, last 1 cycle with rsp_valid=1, all array enables 0 and req_ready=0; DONE->IDLE. For a write, rsp_rdata holds its previous value.
REQ-029 SHALL give write latency accept-edge + ACC_CYC+2 cycles to rsp_valid, and read latency accept-edge + ACC_CYC+3.
REQ-030 SHALL guarantee precharge and any col_sel bit are never 1 in the same cycle, and write_en=1 only while exactly one col_sel bit is 1.
REQ-031 SHALL ignore req_valid while not in IDLE, leaving latched fields unchanged.
REQ-032 SHALL treat the address as fully decoded; every value of req_addr is legal.

Reset
REQ-033 SHALL, on reset=1 at an edge (including mid-access), enter IDLE next cycle with precharge, wl_sel, col_sel, write_en, wdata_drv, sense_en, rsp_valid and rsp_rdata all 0, and counter 0; no rsp_valid for the aborted access.
REQ-034 SHALL have req_ready=0 while reset=1, and 1 in the first cycle after reset deasserts.

Verification (defaults, ACC_CYC=2)
REQ-035 SHALL cover reset: reset held 2 cycles -> all outputs 0; after release req_ready=1.
REQ-036 SHALL cover write: write addr 0x2D with data 0xA5 accepted at cycle 0 -> cycle 1 precharge=1; cycles 2-3 wl_sel bit 11=1, col_sel=0010, write_en=1, wdata_drv=0xA5; cycle 4 rsp_valid=1; then req_ready=1.
REQ-037 SHALL cover read: read addr 0x2D with sa_data=0xA5 -> cycles 2-3 col_sel=0010, write_en=0; cycle 4 sense_en=1; cycle 5 rsp_valid=1 and rsp_rdata=0xA5.
REQ-038 SHALL cover busy: req_valid held high with new addr 0x00 during ACC -> not accepted, wl_sel unchanged, exactly one rsp_valid per accept.
REQ-039 SHALL cover mid-operation reset: reset pulsed in first ACC cycle of a write -> next cycle write_en=0, wl_sel=0, IDLE, no rsp_valid.
REQ-040 SHALL cover column sweep: reads at addr 0,1,2,3 -> col_sel 0001, 0010, 0100, 1000; assertion precharge && |col_sel never fires.
